if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC and issues word requests to instruction memory.
//  Buffers returned words and presents {if_pc, if_instruction} to the IF/ID pipeline register.
//  Honours the ID-side stall and redirects on branch/jump.
//  A redirect is the same event that flushes the IF/ID register.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC fetched first after reset
//  FETCH_DEPTH  2              fetch buffer entries; each entry holds {pc, instr}; must be >=1
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   async active-low reset
//  stall           in   1   IF/ID not accepting; hold presented entry
//  redirect_valid  in   1   branch/jump taken; discard all fetched state
//  redirect_pc     in   32  new fetch target
//  imem_req_valid  out  1   memory request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   read data valid; in order, exactly one per accepted request
//  imem_rsp_data   in   32  instruction word
//  if_valid        out  1   if_pc/if_instruction hold a real fetched instruction
//  if_pc           out  32  PC of presented instruction
//  if_instruction  out  32  presented instruction, or NOP 32'h00000013 when !if_valid
// BEHAVIOUR
//  Reset (async)
//   - fetch_pc=RESET_PC; buffer empty; FSM=IDLE; drop=0.
//   - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=RESET_PC,
//     if_instruction=32'h00000013.
//   - Reset mid-transaction abandons any in-flight response; the memory side is reset together.
//  FSM (at most one outstanding request)
//   - IDLE -> REQ when free slots (FETCH_DEPTH - count) >= 1.
//   - REQ: imem_req_valid=1, imem_req_addr=fetch_pc.
//     - valid and addr held stable until imem_req_ready; never retracted, not even on redirect.
//     - On accept: -> WAIT; fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
//   - WAIT: on imem_rsp_valid, push {req_pc, data} unless drop=1; clear drop; -> IDLE.
//   - Back-to-back permitted: WAIT -> REQ in the same cycle as the response if a slot is free.
//  Consume
//   - if_valid = buffer non-empty.
//   - Head is popped when if_valid && !stall && !redirect_valid.
//   - Push and pop in the same cycle are both allowed; a full buffer with a pop accepts a push.
//  Redirect (redirect_valid=1, highest priority)
//   - Buffer cleared same cycle; if_valid=0 next cycle.
//   - fetch_pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
//   - Request in REQ not yet accepted: it completes with its old address, then drop=1.
//   - Request outstanding in WAIT with no response this cycle: drop=1.
//   - Response in the same cycle as the redirect is discarded.
//   - Redirect in the same cycle as REQ accept: the accepted request is dropped;
//     fetch_pc takes redirect_pc, not +4.
//  Stall
//   - Outputs frozen while stall=1 and buffer non-empty.
//   - Fetching continues until the buffer is full; never overflows.
//  Idle outputs: when !if_valid, if_pc=fetch_pc and if_instruction=NOP.
//  Alignment: imem_req_addr[1:0] is always 2'b00.
// CONFIGURATION
//  FETCH_BYPASS_EN defined
//   - A response arriving while the buffer is empty (and not dropped) drives if_* combinationally
//     that cycle, with if_valid=1.
//   - If also consumed that cycle (!stall), it is not pushed.
//   - Latency: accept->if_valid = memory latency.
//  FETCH_BYPASS_EN undefined
//   - All responses enter the buffer; if_valid rises the cycle after imem_rsp_valid (+1 cycle).
// TESTING
//  - Reset release, 1-cycle memory returning 0xA0..: reqs at 0x0,0x4,0x8;
//    if_pc/if_instruction stream 0x0/0xA0, 0x4/0xA4 with no bubbles beyond memory latency.
//  - stall=1 for 5 cycles, FETCH_DEPTH=2: at most 2 entries held, req_valid=0 while full;
//    outputs stable; release resumes in order with no lost or duplicated PC.
//  - redirect_valid with redirect_pc=0x100 while WAIT: stale response dropped;
//    next if_valid shows if_pc=0x100.
//  - redirect_pc=0x103: imem_req_addr=0x100.
//  - Redirect in the same cycle as imem_rsp_valid: that word is never presented.
//  - imem_req_ready low 4 cycles, then redirect: imem_req_addr stays constant until accept;
//    result dropped.
//  - PC wrap: redirect to 0xFFFF_FFFC: next request 0x0000_0000.
//  - rst_n asserted while WAIT: all outputs return to reset values asynchronously.
//  - Both macro settings: first if_valid lands on the response cycle with FETCH_BYPASS_EN,
//    one cycle later without.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request outstanding, and buffers
// returned {pc, instr} pairs for IF/ID. Optional macro FETCH_BYPASS_EN forwards a response to if_* directly.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FETCH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;
  localparam int PTR_W = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
  localparam int CNT_W = $clog2(FETCH_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FETCH_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FETCH_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t           state, state_n;
  logic [31:0]      fetch_pc, fetch_pc_n, req_addr;
  logic             drop, drop_n;
  logic [CNT_W-1:0] count, count_n;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [31:0]      fb_pc  [FETCH_DEPTH];
  logic [31:0]      fb_ins [FETCH_DEPTH];
  logic             accept, rsp_take, push, pop, bypass_hit, buf_empty, slot_free, enter_req;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign accept    = (state == S_REQ) && imem_req_ready;
  assign rsp_take  = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;
  assign buf_empty = (count == '0);
  assign pop       = !buf_empty && !stall && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  // A word forwarded and consumed in the same cycle never needs a buffer slot.
  assign bypass_hit = rsp_take && buf_empty;
  assign push       = rsp_take && !(bypass_hit && !stall);
`else
  assign bypass_hit = 1'b0;
  assign push       = rsp_take;
`endif

  assign count_n    = redirect_valid ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
  assign slot_free  = (count_n < DEPTH_C);
  assign fetch_pc_n = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) :
                      (accept && !drop) ? (fetch_pc + 32'd4) : fetch_pc;
  assign enter_req  = (state_n == S_REQ) && (state != S_REQ);

  // A redirect cannot retract a request; instead its eventual response is marked for discard.
  always_comb begin
    drop_n = drop;
    if ((state == S_WAIT) && imem_rsp_valid)
      drop_n = 1'b0;
    else if (redirect_valid && ((state == S_REQ) || (state == S_WAIT)))
      drop_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (slot_free) state_n = S_REQ;
      S_REQ:   if (imem_req_ready) state_n = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_n = slot_free ? S_REQ : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC_A;
      req_addr <= RESET_PC_A;
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      fetch_pc <= fetch_pc_n;
      drop     <= drop_n;
      count    <= count_n;
      if (enter_req) req_addr <= fetch_pc_n;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fb_pc[wr_ptr]  <= req_addr;
      fb_ins[wr_ptr] <= imem_rsp_data;
    end
  end

  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_req_addr  = req_addr;
    if_valid       = 1'b0;
    if_pc          = fetch_pc;
    if_instruction = NOP;
    if (bypass_hit) begin
      if_valid       = 1'b1;
      if_pc          = req_addr;
      if_instruction = imem_rsp_data;
    end else if (!buf_empty) begin
      if_valid       = 1'b1;
      if_pc          = fb_pc[rd_ptr];
      if_instruction = fb_ins[rd_ptr];
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against a sequential-PC model.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk, rst_n, stall, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, if_valid;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, if_pc, if_instruction;

  int n_cmp, n_err;
  logic        pend;
  logic [31:0] paddr;
  int          pcnt, lat;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FETCH_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  // Memory model: captures handshakes seen before the edge, answers in order after `lat` cycles.
  task automatic tick();
    logic acc, rg;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    rg  = imem_rsp_valid;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (rg) pend = 1'b0;
    else if (pend && pcnt > 0) pcnt--;
    if (acc) begin
      pend = 1'b1; paddr = a; pcnt = lat - 1;
    end
    imem_rsp_valid = pend && (pcnt == 0);
    imem_rsp_data  = pend ? mem_word(paddr) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; pend = 1'b0; pcnt = 0; paddr = '0; lat = 1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; redirect_pc = '0;
    #3;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr, if_valid, if_pc, if_instruction} !== {1'b0, RESET_PC, 1'b0, RESET_PC, NOP}) begin
      n_err++;
      $display("FAIL reset_outputs got %h want %h", {imem_req_valid, imem_req_addr, if_valid, if_pc, if_instruction},
               {1'b0, RESET_PC, 1'b0, RESET_PC, NOP});
    end
    do_reset();
  endtask

  task automatic test_first_valid();
    logic found;
    do_reset();
    stall = 1'b1; imem_req_ready = 1'b1; lat = 1; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (imem_req_valid) found = 1'b1;
      else tick();
    end
    n_cmp++;
    if (found !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_err++; $display("FAIL first_req found=%0d addr=%h want addr %h", found, imem_req_addr, RESET_PC);
    end
    tick(); #1;
    n_cmp++;
    if (if_valid !== BYP) begin
      n_err++; $display("FAIL first_valid_rsp_cycle got %0d want %0d", if_valid, BYP);
    end
    tick(); #1;
    n_cmp++;
    if ({if_valid, if_pc, if_instruction} !== {1'b1, RESET_PC, mem_word(RESET_PC)}) begin
      n_err++; $display("FAIL first_valid_next got %0d/%h/%h want 1/%h/%h", if_valid, if_pc, if_instruction,
                        RESET_PC, mem_word(RESET_PC));
    end
    stall = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] accs[$];
    int          cyc[$];
    logic [31:0] exp_pc;
    do_reset();
    imem_req_ready = 1'b1; lat = 1; exp_pc = RESET_PC;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (imem_req_valid) accs.push_back(imem_req_addr);
      if (if_valid) begin
        n_cmp++;
        if (if_pc !== exp_pc || if_instruction !== mem_word(exp_pc)) begin
          n_err++; $display("FAIL stream_order got %h/%h want %h/%h", if_pc, if_instruction, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4; cyc.push_back(c);
      end
      tick();
    end
    n_cmp++;
    if (accs.size() < 3) begin
      n_err++; $display("FAIL stream_reqs got %0d requests want >=3", accs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (accs[k] !== RESET_PC + 32'(4 * k)) begin
          n_err++; $display("FAIL stream_req_addr[%0d] got %h want %h", k, accs[k], RESET_PC + 32'(4 * k));
        end
      end
    end
    n_cmp++;
    if (cyc.size() < 8) begin
      n_err++; $display("FAIL stream_count got %0d want >=8", cyc.size());
    end
    for (int k = 1; k < cyc.size(); k++) begin
      n_cmp++;
      if (cyc[k] - cyc[k-1] !== 2) begin
        n_err++; $display("FAIL stream_gap[%0d] got %0d want 2", k, cyc[k] - cyc[k-1]);
      end
    end
  endtask

  task automatic test_stall();
    int nacc, ncons;
    logic [31:0] exp_pc;
    do_reset();
    stall = 1'b1; imem_req_ready = 1'b1; lat = 1; nacc = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (imem_req_valid) nacc++;
      if (c >= 8) begin
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
          n_err++; $display("FAIL stall_full_req got %0d want 0", imem_req_valid);
        end
      end
      if (if_valid) begin
        n_cmp++;
        if (if_pc !== RESET_PC || if_instruction !== mem_word(RESET_PC)) begin
          n_err++; $display("FAIL stall_frozen got %h/%h want %h/%h", if_pc, if_instruction, RESET_PC, mem_word(RESET_PC));
        end
      end
      tick();
    end
    n_cmp++;
    if (nacc !== DEPTH || if_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_fill got %0d reqs valid=%0d want %0d reqs valid=1", nacc, if_valid, DEPTH);
    end
    stall = 1'b0; exp_pc = RESET_PC; ncons = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (if_valid) begin
        n_cmp++;
        if (if_pc !== exp_pc || if_instruction !== mem_word(exp_pc)) begin
          n_err++; $display("FAIL stall_resume got %h/%h want %h/%h", if_pc, if_instruction, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4; ncons++;
      end
      tick();
    end
    n_cmp++;
    if (ncons < 6) begin
      n_err++; $display("FAIL stall_resume_count got %0d want >=6", ncons);
    end
  endtask

  task automatic test_redirect_wait();
    logic found, got_acc, got_v;
    do_reset();
    imem_req_ready = 1'b1; lat = 3; found = 1'b0; got_acc = 1'b0; got_v = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (imem_req_valid) found = 1'b1;
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (found !== 1'b1 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_wait_flush found=%0d if_valid=%0d want 1/0", found, if_valid);
    end
    for (int c = 0; c < 20; c++) begin
      if (!got_acc && imem_req_valid && imem_req_ready) begin
        got_acc = 1'b1; n_cmp++;
        if (imem_req_addr !== 32'h100) begin
          n_err++; $display("FAIL redir_align got %h want 00000100", imem_req_addr);
        end
      end
      if (!got_v && if_valid) begin
        got_v = 1'b1; n_cmp++;
        if (if_pc !== 32'h100 || if_instruction !== mem_word(32'h100)) begin
          n_err++; $display("FAIL redir_wait_first got %h/%h want 00000100/%h", if_pc, if_instruction, mem_word(32'h100));
        end
      end
      tick(); #1;
    end
    n_cmp++;
    if (!(got_acc && got_v)) begin
      n_err++; $display("FAIL redir_wait_timeout acc=%0d valid=%0d want 1/1", got_acc, got_v);
    end
  endtask

  task automatic test_redirect_rsp();
    logic found, got_v;
    do_reset();
    imem_req_ready = 1'b1; lat = 2; found = 1'b0; got_v = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      #1;
      if (imem_rsp_valid) found = 1'b1;
      else tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    n_cmp++;
    if (found !== 1'b1 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_rsp_same found=%0d if_valid=%0d want 1/0", found, if_valid);
    end
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 20 && !got_v; c++) begin
      #1;
      if (if_valid) begin
        got_v = 1'b1; n_cmp++;
        if (if_pc !== 32'h200 || if_instruction !== mem_word(32'h200)) begin
          n_err++; $display("FAIL redir_rsp_first got %h/%h want 00000200/%h", if_pc, if_instruction, mem_word(32'h200));
        end
      end
      tick();
    end
    n_cmp++;
    if (!got_v) begin
      n_err++; $display("FAIL redir_rsp_timeout got no valid want valid");
    end
  endtask

  task automatic test_ready_hold();
    logic found, got_v;
    logic [31:0] a0;
    logic [31:0] accs[$];
    do_reset();
    imem_req_ready = 1'b0; lat = 1; found = 1'b0; got_v = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (imem_req_valid) found = 1'b1;
      else tick();
    end
    a0 = imem_req_addr;
    for (int i = 0; i < 6; i++) begin
      redirect_valid = (i == 2); redirect_pc = 32'h300;
      #1;
      n_cmp++;
      if ({found, imem_req_valid, imem_req_addr} !== {1'b1, 1'b1, a0}) begin
        n_err++; $display("FAIL hold_stable[%0d] got %0d/%0d/%h want 1/1/%h", i, found, imem_req_valid, imem_req_addr, a0);
      end
      tick();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (imem_req_valid) accs.push_back(imem_req_addr);
      if (!got_v && if_valid) begin
        got_v = 1'b1; n_cmp++;
        if (if_pc !== 32'h300 || if_instruction !== mem_word(32'h300)) begin
          n_err++; $display("FAIL hold_first got %h/%h want 00000300/%h", if_pc, if_instruction, mem_word(32'h300));
        end
      end
      tick();
    end
    n_cmp++;
    if (!got_v || accs.size() < 2) begin
      n_err++; $display("FAIL hold_timeout valid=%0d reqs=%0d want 1/>=2", got_v, accs.size());
    end else begin
      n_cmp++;
      if (accs[0] !== a0 || accs[1] !== 32'h300) begin
        n_err++; $display("FAIL hold_req_seq got %h,%h want %h,00000300", accs[0], accs[1], a0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] accs[$];
    logic [31:0] cons[$];
    do_reset();
    imem_req_ready = 1'b1; lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (imem_req_valid) accs.push_back(imem_req_addr);
      if (if_valid) begin
        n_cmp++;
        if (if_instruction !== mem_word(if_pc)) begin
          n_err++; $display("FAIL wrap_data got %h want %h", if_instruction, mem_word(if_pc));
        end
        cons.push_back(if_pc);
      end
      tick();
    end
    n_cmp++;
    if (accs.size() < 2 || cons.size() < 2) begin
      n_err++; $display("FAIL wrap_timeout reqs=%0d cons=%0d want >=2", accs.size(), cons.size());
    end else if ({accs[0], accs[1], cons[0], cons[1]} !== {32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'h0}) begin
      n_err++; $display("FAIL wrap_seq got req %h,%h pc %h,%h want fffffffc,00000000", accs[0], accs[1], cons[0], cons[1]);
    end
  endtask

  task automatic test_async_reset();
    logic found;
    do_reset();
    imem_req_ready = 1'b1; lat = 3; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (imem_req_valid) found = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({found, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instruction} !==
        {1'b1, 1'b0, RESET_PC, 1'b0, RESET_PC, NOP}) begin
      n_err++; $display("FAIL async_reset got %0d/%0d/%h/%0d/%h/%h want 1/0/%h/0/%h/%h", found, imem_req_valid,
                        imem_req_addr, if_valid, if_pc, if_instruction, RESET_PC, RESET_PC, NOP);
    end
    pend = 1'b0; imem_rsp_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, prev_pc, prev_ins;
    logic        prev_hold, prev_rv, prev_frozen, rv;
    int          ncons;
    do_reset();
    exp_pc = RESET_PC; prev_hold = 1'b0; prev_rv = 1'b0; prev_frozen = 1'b0; ncons = 0;
    prev_addr = '0; prev_pc = '0; prev_ins = '0;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 99) < 30);
      imem_req_ready = ($urandom_range(0, 99) < 60);
      lat            = $urandom_range(1, 3);
      rv             = ($urandom_range(0, 99) < 4);
      redirect_valid = rv;
      redirect_pc    = $urandom;
      #1;
      n_cmp++;
      if (imem_req_addr[1:0] !== 2'b00) begin
        n_err++; $display("FAIL rnd_align got %h", imem_req_addr);
      end
      if (prev_hold) begin
        n_cmp++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, prev_addr}) begin
          n_err++; $display("FAIL rnd_req_hold got %0d/%h want 1/%h", imem_req_valid, imem_req_addr, prev_addr);
        end
      end
      if (prev_rv) begin
        n_cmp++;
        if (if_valid !== 1'b0) begin
          n_err++; $display("FAIL rnd_redirect_flush got %0d want 0", if_valid);
        end
      end
      if (prev_frozen) begin
        n_cmp++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, prev_pc, prev_ins}) begin
          n_err++; $display("FAIL rnd_stall_frozen got %0d/%h/%h want 1/%h/%h", if_valid, if_pc, if_instruction, prev_pc, prev_ins);
        end
      end
      n_cmp++;
      if (if_instruction !== (if_valid ? mem_word(if_pc) : NOP)) begin
        n_err++; $display("FAIL rnd_instr got %h want %h", if_instruction, if_valid ? mem_word(if_pc) : NOP);
      end
      if (imem_req_valid && imem_req_ready) begin
        n_cmp++;
        if (pend !== 1'b0) begin
          n_err++; $display("FAIL rnd_outstanding got 2 want <=1");
        end
      end
      if (if_valid && !stall && !rv) begin
        n_cmp++;
        if (if_pc !== exp_pc) begin
          n_err++; $display("FAIL rnd_pc_order got %h want %h", if_pc, exp_pc);
        end
        exp_pc += 4; ncons++;
      end
      if (rv) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      prev_hold = imem_req_valid && !imem_req_ready; prev_addr = imem_req_addr;
      prev_rv = rv; prev_frozen = if_valid && stall && !rv; prev_pc = if_pc; prev_ins = if_instruction;
      tick();
    end
    redirect_valid = 1'b0; stall = 1'b0;
    n_cmp++;
    if (ncons < 100) begin
      n_err++; $display("FAIL rnd_progress got %0d consumed want >=100", ncons);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_first_valid();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_ready_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
